// File: rtl/sw_debounce_if.sv
// Switch-conditioner signal bundle: raw pin in, clean level/pulses/press count out.
// The master side owns the raw pin; the slave side (the debouncer) drives the results.
interface sw_debounce_if;
  logic       sw_in;
  logic       sw_level;
  logic       sw_rise;
  logic       sw_fall;
  logic       sw_long;
  logic [7:0] press_cnt;

  modport master (
    output sw_in,
    input  sw_level, sw_rise, sw_fall, sw_long, press_cnt
  );

  modport slave (
    input  sw_in,
    output sw_level, sw_rise, sw_fall, sw_long, press_cnt
  );
endinterface

// File: rtl/sw_debounce.sv
// Switch/push-button conditioner: 2-flop synchroniser, hold-time debounce FSM, edge pulses,
// wrapping press counter. Define SW_LONGPRESS_EN to enable the one-shot long-press pulse.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input logic          CLK,
  input logic          NRST,
  sw_debounce_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

  logic          s1, s2;
  logic [1:0]    state, next_state;
  logic [DW-1:0] dcnt, dcnt_next;
  logic          rise_now, fall_now;
  logic          level_next;
  logic          level_q, rise_q, fall_q;
  logic [7:0]    press_q;

  // NOTE: s1 is metastability settling only; nothing but s2 may look at it.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.sw_in;
      s2 <= s1;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    dcnt_next  = dcnt;
    rise_now   = 1'b0;
    fall_now   = 1'b0;
    case (state)
      ST_STABLE_LOW: begin
        if (s2) begin
          next_state = ST_CHECK_HIGH;
          dcnt_next  = '0;
        end
      end
      ST_CHECK_HIGH: begin
        if (!s2) begin
          next_state = ST_STABLE_LOW;
        end else if (dcnt == D_LAST) begin
          next_state = ST_STABLE_HIGH;
          rise_now   = 1'b1;
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      ST_STABLE_HIGH: begin
        if (!s2) begin
          next_state = ST_CHECK_LOW;
          dcnt_next  = '0;
        end
      end
      ST_CHECK_LOW: begin
        if (s2) begin
          next_state = ST_STABLE_HIGH;
        end else if (dcnt == D_LAST) begin
          next_state = ST_STABLE_LOW;
          fall_now   = 1'b1;
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      default: next_state = ST_STABLE_LOW;
    endcase
  end

  assign level_next = (next_state == ST_STABLE_HIGH) || (next_state == ST_CHECK_LOW);

  // Outputs are registered from next-state decode so they change on the accepting edge.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state   <= ST_STABLE_LOW;
      dcnt    <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= 8'd0;
    end else begin
      state   <= next_state;
      dcnt    <= dcnt_next;
      level_q <= level_next;
      rise_q  <= rise_now;
      fall_q  <= fall_now;
      if (rise_now)
        press_q <= press_q + 8'd1;
    end
  end

  assign bus.sw_level  = level_q;
  assign bus.sw_rise   = rise_q;
  assign bus.sw_fall   = fall_q;
  assign bus.press_cnt = press_q;

`ifdef SW_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt;
  logic          long_fired;
  logic          long_q;
  logic          level_state;
  logic          long_now;

  assign level_state = (state == ST_STABLE_HIGH) || (state == ST_CHECK_LOW);
  // long_fired keeps the pulse one-shot while lcnt sits at its terminal value.
  assign long_now    = level_state && (lcnt == L_LAST) && !long_fired;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      lcnt       <= '0;
      long_fired <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      long_q <= long_now;
      if (next_state == ST_STABLE_LOW || rise_now) begin
        lcnt       <= '0;
        long_fired <= 1'b0;
      end else if (level_state) begin
        if (lcnt != L_LAST)
          lcnt <= lcnt + 1'b1;
        if (long_now)
          long_fired <= 1'b1;
      end
    end
  end

  assign bus.sw_long = long_q;
`else
  assign bus.sw_long = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed steps plus random bounce, compared each cycle
// against a sample-run-length reference model.
module tb_sw_debounce;
  localparam int D = 4;
  localparam int L = 10;

`ifdef SW_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic NRST = 1'b0;

  sw_debounce_if bus ();

  sw_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .CLK (CLK),
    .NRST(NRST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the pin reaches the FSM two samples late; a new level is accepted once
  // the delayed pin has disagreed with the current level for D+1 consecutive samples.
  bit       hist[$];
  bit       m_level;
  int       m_run;
  int       m_since;
  logic [7:0] m_press;
  bit       m_rise, m_fall, m_long;
  int       rise_seen, fall_seen, long_seen;

  task automatic model_reset();
    hist = {1'b0, 1'b0};
    m_level = 1'b0;
    m_run   = 0;
    m_since = 0;
    m_press = 8'd0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_long  = 1'b0;
  endtask

  task automatic model_edge(input bit v);
    bit delayed;
    delayed = hist.pop_front();
    hist.push_back(v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_long = 1'b0;
    if (m_level) begin
      m_since++;
      if (LONG_EN && m_since == L)
        m_long = 1'b1;
    end
    if (delayed != m_level) m_run++;
    else                    m_run = 0;
    if (m_run == D + 1) begin
      m_level = ~m_level;
      m_run   = 0;
      if (m_level) begin
        m_rise  = 1'b1;
        m_press = m_press + 8'd1;
        m_since = 0;
      end else begin
        m_fall = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("level", 32'(bus.sw_level), 32'(m_level));
    check("rise",  32'(bus.sw_rise),  32'(m_rise));
    check("fall",  32'(bus.sw_fall),  32'(m_fall));
    check("long",  32'(bus.sw_long),  32'(m_long));
    check("press", 32'(bus.press_cnt), 32'(m_press));
    if (bus.sw_rise === 1'b1) rise_seen++;
    if (bus.sw_fall === 1'b1) fall_seen++;
    if (bus.sw_long === 1'b1) long_seen++;
  endtask

  task automatic cycle(input bit v);
    bus.sw_in = v;
    @(posedge CLK);
    model_edge(v);
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(bus.sw_level), 32'd0);
    check({tag, "_rise"},  32'(bus.sw_rise),  32'd0);
    check({tag, "_fall"},  32'(bus.sw_fall),  32'd0);
    check({tag, "_long"},  32'(bus.sw_long),  32'd0);
    check({tag, "_press"}, 32'(bus.press_cnt), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at, fall_at;
    int r0, f0, l0;
    bit v;

    // Power-on reset with the pin low.
    model_reset();
    rise_seen = 0; fall_seen = 0; long_seen = 0;
    bus.sw_in = 1'b0;
    NRST = 1'b0;
    #12;
    check_reset_outputs("por");
    @(negedge CLK);
    NRST = 1'b1;
    repeat (20) cycle(1'b0);

    // Clean press: rise expected on the 7th sampled edge (index 6).
    rise_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      if (bus.sw_rise === 1'b1 && rise_at < 0) rise_at = i;
    end
    check("rise_latency", 32'(rise_at), 32'd6);
    check("press_first", 32'(bus.press_cnt), 32'd1);
    repeat (20) cycle(1'b1);
    repeat (15) cycle(1'b0);

    // Short glitch from stable low is rejected.
    r0 = rise_seen;
    repeat (3)  cycle(1'b1);
    repeat (12) cycle(1'b0);
    check("glitch_no_rise", 32'(rise_seen - r0), 32'd0);
    check("glitch_press",   32'(bus.press_cnt), 32'd1);

    // Bouncy release: low 2, high 1, then low held; one fall 6 edges after the final low.
    repeat (12) cycle(1'b1);
    f0 = fall_seen;
    repeat (2) cycle(1'b0);
    cycle(1'b1);
    fall_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0);
      if (bus.sw_fall === 1'b1 && fall_at < 0) fall_at = i;
    end
    check("fall_latency", 32'(fall_at), 32'd6);
    check("fall_single",  32'(fall_seen - f0), 32'd1);

    // Random bounce bursts.
    for (int b = 0; b < 120; b++) begin
      v = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) cycle(v);
    end
    repeat (20) cycle(1'b0);

    // 256 clean presses from a fresh reset: counter wraps back to 0.
    NRST = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst2");
    @(negedge CLK);
    NRST = 1'b1;
    r0 = rise_seen; f0 = fall_seen; l0 = long_seen;
    for (int p = 0; p < 256; p++) begin
      repeat (25) cycle(1'b1);
      repeat (12) cycle(1'b0);
    end
    check("wrap_rises", 32'(rise_seen - r0), 32'd256);
    check("wrap_falls", 32'(fall_seen - f0), 32'd256);
    check("wrap_longs", 32'(long_seen - l0), LONG_EN ? 32'd256 : 32'd0);
    check("wrap_press", 32'(bus.press_cnt), 32'd0);

    // Reset while debouncing a rise (dcnt=2 after the 5th high sample), pin held high.
    repeat (5) cycle(1'b1);
    #2;
    NRST = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    @(negedge CLK);
    NRST = 1'b1;
    rise_at = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1);
      if (bus.sw_rise === 1'b1 && rise_at < 0) rise_at = i;
    end
    check("midrst_rise_latency", 32'(rise_at), 32'd6);
    check("midrst_press", 32'(bus.press_cnt), 32'd1);
    repeat (15) cycle(1'b1);
    repeat (10) cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
